// File: rtl/score_text_seq_pkg.sv
// rtl/score_text_seq_pkg.sv - shared state encoding and constants for the score text writer
package score_text_seq_pkg;

    typedef enum logic [1:0] {
        ST_LABEL   = 2'd0,
        ST_IDLE    = 2'd1,
        ST_CONVERT = 2'd2,
        ST_WRITE   = 2'd3
    } state_t;

    localparam int NUM_DIGITS  = 5;
    localparam int CONV_CYCLES = 16;
    localparam int LABEL_LEN   = 6;

    // "SCORE " written once after reset
    function automatic logic [7:0] label_char(input logic [2:0] i);
        case (i)
            3'd0:    label_char = 8'd83;
            3'd1:    label_char = 8'd67;
            3'd2:    label_char = 8'd79;
            3'd3:    label_char = 8'd82;
            3'd4:    label_char = 8'd69;
            default: label_char = 8'd32;
        endcase
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential shift-add-3 binary to 5-digit BCD converter
// Ports: clk, rst (sync active-low), start (loads bin_in), bin_in[15:0],
//        done (one-cycle pulse, bcd valid from then on), bcd (5x4-bit, [4] = MSD).
module bin2bcd_seq
    import score_text_seq_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [15:0]                bin_in,
    output logic                       done,
    output logic [NUM_DIGITS-1:0][3:0] bcd
);

    logic [15:0]             sh;
    logic [NUM_DIGITS*4-1:0] acc;
    logic [4:0]              cnt;
    logic                    running;

    function automatic logic [NUM_DIGITS*4-1:0] add3(input logic [NUM_DIGITS*4-1:0] v);
        logic [NUM_DIGITS*4-1:0] r;
        r = v;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            if (r[4*d +: 4] >= 4'd5) r[4*d +: 4] = r[4*d +: 4] + 4'd3;
        end
        return r;
    endfunction

    logic [NUM_DIGITS*4-1:0] adj;
    assign adj = add3(acc);
    assign bcd = acc;

    always_ff @(posedge clk) begin
        if (!rst) begin
            sh      <= '0;
            acc     <= '0;
            cnt     <= '0;
            running <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                // The first shift is fused with the load (nothing to adjust on an
                // all-zero accumulator), so the result is ready in the 16th cycle.
                acc     <= {{(NUM_DIGITS*4-1){1'b0}}, bin_in[15]};
                sh      <= {bin_in[14:0], 1'b0};
                cnt     <= 5'd1;
                running <= 1'b1;
            end else if (running) begin
                acc <= {adj[NUM_DIGITS*4-2:0], sh[15]};
                sh  <= {sh[14:0], 1'b0};
                cnt <= cnt + 5'd1;
                if (cnt == 5'(CONV_CYCLES - 1)) begin
                    running <= 1'b0;
                    done    <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/score_text_seq.sv
// rtl/score_text_seq.sv - writes "SCORE " and a 5-digit decimal score into a text line buffer
// Ports: clk, rst (sync active-low), vblnk_in, score_in[15:0] ->
//        buf_we, buf_addr[3:0], buf_data[7:0], busy, update_done (all registered).
// Option: SCORE_BLANK_ZEROS_EN writes leading zero digits as ASCII_SPACE.
module score_text_seq
    import score_text_seq_pkg::*;
#(
    parameter int         DIGIT_BASE  = 6,
    parameter logic [7:0] ASCII_ZERO  = 8'd48,
    parameter logic [7:0] ASCII_SPACE = 8'd32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        vblnk_in,
    input  logic [15:0] score_in,
    output logic        buf_we,
    output logic [3:0]  buf_addr,
    output logic [7:0]  buf_data,
    output logic        busy,
    output logic        update_done
);

    if (DIGIT_BASE < 0 || DIGIT_BASE + NUM_DIGITS - 1 > 15) begin : g_base_check
        $error("DIGIT_BASE leaves no room for five digit slots in a 16-slot line");
    end

    state_t                    state, state_d;
    logic [2:0]                idx, idx_d;
    logic                      vblnk_q;
    logic                      conv_valid;
    logic [15:0]               last_val;
    logic                      conv_start, conv_done;
    logic [NUM_DIGITS-1:0][3:0] bcd;
    logic [NUM_DIGITS*4-1:0]   bcd_flat;
    logic                      we_d, done_d, busy_d;
    logic [3:0]                addr_d;
    logic [7:0]                data_d;
    logic [4:0]                shamt;
    logic [7:0]                digit_char;

    bin2bcd_seq u_bcd (
        .clk    (clk),
        .rst    (rst),
        .start  (conv_start),
        .bin_in (score_in),
        .done   (conv_done),
        .bcd    (bcd)
    );

    assign bcd_flat = bcd;
    // Shifting the selected digit (and everything above it) down to bit 0
    assign shamt = 5'd16 - {idx, 2'b00};

    always_comb begin
`ifdef SCORE_BLANK_ZEROS_EN
        // Zero digit with only zeros above it is a leading zero; the last digit always prints
        if ((bcd_flat >> shamt) == '0 && idx != 3'(NUM_DIGITS - 1))
            digit_char = ASCII_SPACE;
        else
            digit_char = ASCII_ZERO + {4'd0, 4'(bcd_flat >> shamt)};
`else
        digit_char = ASCII_ZERO + {4'd0, 4'(bcd_flat >> shamt)};
`endif
    end

    always_comb begin
        state_d    = state;
        idx_d      = idx;
        we_d       = 1'b0;
        addr_d     = buf_addr;
        data_d     = buf_data;
        done_d     = 1'b0;
        conv_start = 1'b0;
        case (state)
            ST_LABEL: begin
                we_d   = 1'b1;
                addr_d = {1'b0, idx};
                data_d = label_char(idx);
                if (idx == 3'(LABEL_LEN - 1)) begin
                    state_d = ST_IDLE;
                    idx_d   = 3'd0;
                end else begin
                    idx_d = idx + 3'd1;
                end
            end
            ST_IDLE: begin
                if (vblnk_in && !vblnk_q && (!conv_valid || score_in != last_val)) begin
                    state_d    = ST_CONVERT;
                    conv_start = 1'b1;
                end
            end
            ST_CONVERT: begin
                // The first digit is issued on the same edge that leaves CONVERT so
                // that, with registered outputs, it appears in the first WRITE cycle.
                if (conv_done) begin
                    state_d = ST_WRITE;
                    if (vblnk_in) begin
                        we_d   = 1'b1;
                        addr_d = 4'(DIGIT_BASE) + {1'b0, idx};
                        data_d = digit_char;
                        idx_d  = idx + 3'd1;
                    end
                end
            end
            ST_WRITE: begin
                if (idx == 3'(NUM_DIGITS)) begin
                    state_d = ST_IDLE;
                    idx_d   = 3'd0;
                    done_d  = 1'b1;
                end else if (vblnk_in) begin
                    we_d   = 1'b1;
                    addr_d = 4'(DIGIT_BASE) + {1'b0, idx};
                    data_d = digit_char;
                    idx_d  = idx + 3'd1;
                end
            end
            default: state_d = ST_LABEL;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= ST_LABEL;
            idx         <= 3'd0;
            vblnk_q     <= 1'b0;
            conv_valid  <= 1'b0;
            last_val    <= 16'd0;
            buf_we      <= 1'b0;
            buf_addr    <= 4'd0;
            buf_data    <= 8'd0;
            busy        <= 1'b0;
            update_done <= 1'b0;
        end else begin
            state       <= state_d;
            idx         <= idx_d;
            vblnk_q     <= vblnk_in;
            buf_we      <= we_d;
            buf_addr    <= addr_d;
            buf_data    <= data_d;
            busy        <= busy_d;
            update_done <= done_d;
            if (conv_start) begin
                conv_valid <= 1'b1;
                last_val   <= score_in;
            end
        end
    end

endmodule

// File: tb/tb_score_text_seq.sv
// tb/tb_score_text_seq.sv - self-checking bench for score_text_seq
module tb_score_text_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        vblnk_in = 1'b0;
    logic [15:0] score_in = 16'd0;
    logic        buf_we;
    logic [3:0]  buf_addr;
    logic [7:0]  buf_data;
    logic        busy;
    logic        update_done;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int busy_cnt = 0;

    typedef struct {
        int c;
        int addr;
        int data;
    } wr_t;

    wr_t wlog[$];
    int  dlog[$];
    int  label_ref[6] = '{83, 67, 79, 82, 69, 32};

    // reference state: value of the last conversion and whether one happened since reset
    bit  conv_valid = 1'b0;
    int  last_conv = 0;

    score_text_seq dut (
        .clk         (clk),
        .rst         (rst),
        .vblnk_in    (vblnk_in),
        .score_in    (score_in),
        .buf_we      (buf_we),
        .buf_addr    (buf_addr),
        .buf_data    (buf_data),
        .busy        (busy),
        .update_done (update_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always begin
        @(posedge clk);
        #2;
        if (buf_we) begin
            wr_t e;
            e.c = cyc;
            e.addr = int'(buf_addr);
            e.data = int'(buf_data);
            wlog.push_back(e);
        end
        if (update_done) dlog.push_back(cyc);
        if (busy) busy_cnt++;
    end

    function automatic int exp_char(input int v, input int i);
        int p = 1;
        for (int k = 0; k < 4 - i; k++) p = p * 10;
`ifdef SCORE_BLANK_ZEROS_EN
        if (i < 4 && v < p) return 32;
`endif
        return 48 + (v / p) % 10;
    endfunction

    task automatic test_reset;
        int r;
        rst = 1'b0;
        vblnk_in = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (buf_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %0b want 0", buf_we); end
        checks++; if (buf_addr !== 4'd0) begin errors++; $display("FAIL reset_addr: got %0d want 0", buf_addr); end
        checks++; if (buf_data !== 8'd0) begin errors++; $display("FAIL reset_data: got %0d want 0", buf_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b want 0", busy); end
        checks++; if (update_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %0b want 0", update_done); end
        wlog.delete();
        r = cyc;
        rst = 1'b1;
        conv_valid = 1'b0;
        last_conv = 0;
        repeat (10) @(negedge clk);
        checks++;
        if (wlog.size() !== 6) begin errors++; $display("FAIL label_count: got %0d want 6", wlog.size()); end
        for (int i = 0; i < 6 && i < wlog.size(); i++) begin
            checks++;
            if (wlog[i].c !== r + 1 + i || wlog[i].addr !== i || wlog[i].data !== label_ref[i]) begin
                errors++;
                $display("FAIL label%0d: cycle=%0d addr=%0d data=%0d want cycle=%0d addr=%0d data=%0d",
                         i, wlog[i].c, wlog[i].addr, wlog[i].data, r + 1 + i, i, label_ref[i]);
            end
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL label_busy: got %0b want 0", busy); end
    endtask

    task automatic test_conversion(input int v);
        int  n;
        bit  expect_conv;
        expect_conv = !conv_valid || (v != last_conv);
        score_in = 16'(v);
        vblnk_in = 1'b0;
        repeat (2) @(negedge clk);
        wlog.delete();
        dlog.delete();
        n = cyc;
        vblnk_in = 1'b1;
        @(negedge clk);
        busy_cnt = 0;
        if (expect_conv) begin
            checks++;
            if (busy !== 1'b1) begin errors++; $display("FAIL conv_busy v=%0d: got %0b want 1", v, busy); end
        end
        repeat (22) @(negedge clk);
        vblnk_in = 1'b0;
        if (expect_conv) begin
            conv_valid = 1'b1;
            last_conv = v;
            checks++;
            if (wlog.size() !== 5) begin errors++; $display("FAIL conv_count v=%0d: got %0d want 5", v, wlog.size()); end
            for (int i = 0; i < 5 && i < wlog.size(); i++) begin
                checks++;
                if (wlog[i].c !== n + 17 + i || wlog[i].addr !== 6 + i || wlog[i].data !== exp_char(v, i)) begin
                    errors++;
                    $display("FAIL conv v=%0d digit%0d: cycle=%0d addr=%0d data=%0d want cycle=%0d addr=%0d data=%0d",
                             v, i, wlog[i].c, wlog[i].addr, wlog[i].data, n + 17 + i, 6 + i, exp_char(v, i));
                end
            end
            checks++;
            if (dlog.size() !== 1 || dlog[0] !== n + 22) begin
                errors++;
                $display("FAIL conv_done v=%0d: pulses=%0d first=%0d want 1 pulse at %0d",
                         v, dlog.size(), (dlog.size() > 0) ? dlog[0] : -1, n + 22);
            end
            checks++;
            if (busy !== 1'b0) begin errors++; $display("FAIL conv_idle v=%0d: busy=%0b want 0", v, busy); end
        end else begin
            checks++;
            if (wlog.size() !== 0 || dlog.size() !== 0 || busy_cnt !== 0) begin
                errors++;
                $display("FAIL same_score v=%0d: writes=%0d done=%0d busy_cycles=%0d want 0 0 0",
                         v, wlog.size(), dlog.size(), busy_cnt);
            end
        end
    endtask

    task automatic test_vblank_gap(input int v, input int gap);
        int n;
        int ec;
        score_in = 16'(v);
        vblnk_in = 1'b0;
        repeat (2) @(negedge clk);
        wlog.delete();
        dlog.delete();
        n = cyc;
        vblnk_in = 1'b1;
        for (int k = 1; k <= 24 + gap; k++) begin
            @(negedge clk);
            if (k == 5) score_in = 16'(v) ^ 16'h5a5a;
            if (k == 18) vblnk_in = 1'b0;
            if (k == 18 + gap) vblnk_in = 1'b1;
        end
        vblnk_in = 1'b0;
        conv_valid = 1'b1;
        last_conv = v;
        checks++;
        if (wlog.size() !== 5) begin errors++; $display("FAIL gap_count: got %0d want 5", wlog.size()); end
        for (int i = 0; i < 5 && i < wlog.size(); i++) begin
            ec = (i < 2) ? n + 17 + i : n + 17 + i + gap;
            checks++;
            if (wlog[i].c !== ec || wlog[i].addr !== 6 + i || wlog[i].data !== exp_char(v, i)) begin
                errors++;
                $display("FAIL gap digit%0d: cycle=%0d addr=%0d data=%0d want cycle=%0d addr=%0d data=%0d",
                         i, wlog[i].c, wlog[i].addr, wlog[i].data, ec, 6 + i, exp_char(v, i));
            end
        end
        checks++;
        if (dlog.size() !== 1 || dlog[0] !== n + 22 + gap) begin
            errors++;
            $display("FAIL gap_done: pulses=%0d first=%0d want 1 pulse at %0d",
                     dlog.size(), (dlog.size() > 0) ? dlog[0] : -1, n + 22 + gap);
        end
    endtask

    task automatic test_reset_mid_convert(input int v);
        int r;
        score_in = 16'(v);
        vblnk_in = 1'b0;
        repeat (2) @(negedge clk);
        vblnk_in = 1'b1;
        repeat (6) @(negedge clk);
        wlog.delete();
        rst = 1'b0;
        vblnk_in = 1'b0;
        repeat (2) @(negedge clk);
        r = cyc;
        rst = 1'b1;
        conv_valid = 1'b0;
        last_conv = 0;
        repeat (30) @(negedge clk);
        checks++;
        if (wlog.size() !== 6) begin errors++; $display("FAIL abort_count: got %0d writes want 6", wlog.size()); end
        for (int i = 0; i < 6 && i < wlog.size(); i++) begin
            checks++;
            if (wlog[i].c !== r + 1 + i || wlog[i].addr !== i || wlog[i].data !== label_ref[i]) begin
                errors++;
                $display("FAIL abort_label%0d: cycle=%0d addr=%0d data=%0d want cycle=%0d addr=%0d data=%0d",
                         i, wlog[i].c, wlog[i].addr, wlog[i].data, r + 1 + i, i, label_ref[i]);
            end
        end
    endtask

    initial begin
        int v;
        test_reset();
        test_conversion(1234);
        test_conversion(65535);
        test_conversion(65535);
        test_conversion(0);
        test_conversion(9);
        for (int i = 0; i < 5; i++) begin
            v = int'($urandom_range(0, 65535));
            if (v == last_conv) v = v ^ 1;
            test_conversion(v);
        end
        v = int'($urandom_range(0, 65535));
        if (v == last_conv) v = v ^ 1;
        test_vblank_gap(v, 3);
        test_reset_mid_convert(4321);
        test_conversion(4321);
        test_conversion(100);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/score_text_seq.md
SCORE_TEXT_SEQ -- requirements
Module: score_text_seq

Interface
REQ-001 SHALL have parameter DIGIT_BASE, default 6, char-buffer slot of the most significant score digit.
REQ-002 SHALL have parameter ASCII_ZERO, default 48, code of glyph '0' in the font ROM.
REQ-003 SHALL have parameter ASCII_SPACE, default 32, code written for blanked digits.
REQ-004 SHALL have the port list, clock and reset first:
- clk  in  1  pixel clock, the only clock.
- rst  in  1  reset: synchronous, active-low.
- vblnk_in  in  1  vertical blanking from the timing chain.
- score_in  in  16  binary score, sampled only as in REQ-008.
- buf_we  out  1  char-buffer write strobe.
- buf_addr  out  4  char-buffer slot, 0..15, one 16-char text line.
- buf_data  out  8  ASCII code to write.
- busy  out  1  high whenever state is not IDLE.
- update_done  out  1  one-cycle pulse after the last digit write.

Function
REQ-005 SHALL register all outputs; there is no combinational path from input to output.
REQ-006 SHALL implement the FSM LABEL -> IDLE -> CONVERT -> WRITE -> IDLE.
REQ-007 In LABEL, SHALL write "SCORE " (83,67,79,82,69,32) to slots 0..5, one per cycle, ungated by vblnk_in, then enter IDLE.
REQ-008 In IDLE, on a vblnk_in rising edge (high now, low the previous cycle), SHALL latch score_in and enter CONVERT if it differs from the last converted value or no conversion has happened since reset; otherwise it SHALL stay in IDLE with no writes.
REQ-009 CONVERT SHALL run a shift-add-3 binary-to-BCD conversion of exactly 16 cycles, producing 5 BCD digits (max 65535).
REQ-010 WRITE SHALL emit the digits MSD first to slots DIGIT_BASE..DIGIT_BASE+4, one per cycle, with buf_data = ASCII_ZERO + digit.
REQ-011 WRITE SHALL assert buf_we only while vblnk_in is high; while vblnk_in is low it SHALL hold the digit index, keep buf_we low, and resume at the same digit when vblnk_in is next high.
REQ-012 Latency: edge detected in cycle N -> CONVERT in N+1..N+16 -> writes in N+17..N+21 (vblnk_in held high) -> update_done high and busy low in N+22.
REQ-013 score_in changes and vblnk_in edges during CONVERT or WRITE SHALL be ignored; the new value is taken at the next qualifying edge in IDLE.
REQ-014 Slot arithmetic SHALL be 4-bit; DIGIT_BASE+4 > 15 is illegal and SHALL be flagged by an elaboration-time check.

Reset
REQ-015 While rst is low at a clk edge: buf_we=0, buf_addr=0, buf_data=0, busy=0, update_done=0, state=LABEL, conversion-done flag cleared, last value=0.
REQ-016 Reset asserted mid-CONVERT or mid-WRITE SHALL abandon the operation; after release the block restarts with LABEL.

Configuration
REQ-017 With SCORE_BLANK_ZEROS_EN defined, leading zero digits SHALL be written as ASCII_SPACE; the least significant digit is always numeric.
REQ-018 Without SCORE_BLANK_ZEROS_EN, all 5 digits SHALL be written numerically, including leading zeros.

Structure
REQ-019 A shared package SHALL hold the FSM state encoding, the label character constants, the digit count (5), and the conversion cycle count (16).
REQ-020 The BCD converter SHALL be a sub-module named bin2bcd_seq, with a start/done handshake and 5x4-bit output.

Verification
REQ-021 Reset release -> six writes 83,67,79,82,69,32 to slots 0..5 on consecutive cycles, then busy=0.
REQ-022 score_in=1234, vblnk_in rise at cycle N -> slots 6..10 get 48,49,50,51,52 in N+17..N+21; update_done in N+22. With SCORE_BLANK_ZEROS_EN: 32,49,50,51,52.
REQ-023 score_in=65535 -> 54,53,53,51,53. score_in=0 with SCORE_BLANK_ZEROS_EN -> 32,32,32,32,48.
REQ-024 vblnk_in drops after the 2nd digit write -> no writes while low; digits 3..5 written once vblnk_in returns high; exactly 5 writes in total.
REQ-025 Same score at two consecutive vblank edges -> second edge produces no writes and no busy; reset low during CONVERT -> no digit writes, LABEL sequence repeats.
